// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory block: access type codes, size decode
// and controller state encoding.
package dm_pkg;

    localparam logic [2:0] DM_WORD  = 3'b000;
    localparam logic [2:0] DM_HALF  = 3'b001;
    localparam logic [2:0] DM_HALFU = 3'b010;
    localparam logic [2:0] DM_BYTE  = 3'b011;
    localparam logic [2:0] DM_BYTEU = 3'b100;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } dm_state_e;

    // Access size in bytes; 0 marks an unsupported type code.
    function automatic logic [2:0] dm_size(input logic [2:0] acc_type);
        logic [2:0] size;
        case (acc_type)
            DM_WORD:            size = 3'd4;
            DM_HALF, DM_HALFU:  size = 3'd2;
            DM_BYTE, DM_BYTEU:  size = 3'd1;
            default:            size = 3'd0;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for one access over a two-word window: byte enables and
// shifted store data per beat, plus load merge and sign/zero extension.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [2:0]  acc_type,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_lo,
    input  logic [31:0] rd_hi,
    output logic        bad_type,
    output logic        crossing,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wd_lo,
    output logic [31:0] wd_hi,
    output logic [31:0] rdata
);

    logic [3:0]  size_mask;
    logic [7:0]  span;
    logic [4:0]  sh;
    logic [31:0] rd_sh;

    always_comb begin
        sh = {lane, 3'b000};
        case (dm_size(acc_type))
            3'd4:    size_mask = 4'b1111;
            3'd2:    size_mask = 4'b0011;
            3'd1:    size_mask = 4'b0001;
            default: size_mask = 4'b0000;
        endcase
        bad_type = (size_mask == 4'b0000);

        // Bytes of the window [word N | word N+1] touched by this access.
        span     = {4'b0000, size_mask} << lane;
        be_lo    = span[3:0];
        be_hi    = span[7:4];
        crossing = |span[7:4];

        {wd_hi, wd_lo} = {32'h0, wdata} << sh;
        rd_sh          = 32'({rd_hi, rd_lo} >> sh);

        case (acc_type)
            DM_WORD:  rdata = rd_sh;
            DM_HALF:  rdata = {{16{rd_sh[15]}}, rd_sh[15:0]};
            DM_HALFU: rdata = {16'h0, rd_sh[15:0]};
            DM_BYTE:  rdata = {{24{rd_sh[7]}}, rd_sh[7:0]};
            DM_BYTEU: rdata = {24'h0, rd_sh[7:0]};
            default:  rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dm_param.sv
// Byte-addressable data memory with single-cycle aligned accesses and optional
// two-beat handling of accesses that cross a word boundary.
//
// state    | meaning
// ST_IDLE  | accepting requests; aligned accesses and faults complete here
// ST_SPLIT | second beat of a word-crossing access on word N+1
module dm_param
    import dm_pkg::*;
#(
    parameter int ADDR_W         = 9,
    parameter int ALLOW_MISALIGN = 1,
    parameter int TRACE          = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault
);

    localparam int WORD_W = ADDR_W - 2;
    localparam int DEPTH  = 1 << WORD_W;

    dm_state_e         state, state_nx;
    logic [31:0]       mem [DEPTH];

    logic              cap_we;
    logic [2:0]        cap_type;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;
    logic [31:0]       cap_rlo;

    logic              in_split, hs, fault, wr_en;
    logic              cur_we;
    logic [2:0]        cur_type;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic [WORD_W-1:0] cur_word, nxt_word, wr_word;
    logic [31:0]       rd_lo, rd_hi, rdata, wd_lo, wd_hi, wr_data;
    logic [3:0]        be_lo, be_hi, wr_be;
    logic              bad_type, crossing;

    assign in_split  = (state == ST_SPLIT);
    assign req_ready = (state == ST_IDLE);
    assign hs        = req_valid && req_ready;

    // In SPLIT everything is driven from the captured request.
    assign cur_we    = in_split ? cap_we    : req_we;
    assign cur_type  = in_split ? cap_type  : req_type;
    assign cur_addr  = in_split ? cap_addr  : req_addr;
    assign cur_wdata = in_split ? cap_wdata : req_wdata;
    assign cur_word  = cur_addr[ADDR_W-1:2];
    assign nxt_word  = cur_word + WORD_W'(1);

    assign rd_lo = in_split ? cap_rlo : mem[cur_word];
    assign rd_hi = mem[nxt_word];

    dm_lane_align u_align (
        .acc_type (cur_type),
        .lane     (cur_addr[1:0]),
        .wdata    (cur_wdata),
        .rd_lo    (rd_lo),
        .rd_hi    (rd_hi),
        .bad_type (bad_type),
        .crossing (crossing),
        .be_lo    (be_lo),
        .be_hi    (be_hi),
        .wd_lo    (wd_lo),
        .wd_hi    (wd_hi),
        .rdata    (rdata)
    );

    assign fault   = bad_type || (crossing && (ALLOW_MISALIGN == 0));
    assign wr_en   = !rst && cur_we && (in_split || (hs && !fault));
    assign wr_word = in_split ? nxt_word : cur_word;
    assign wr_be   = in_split ? be_hi    : be_lo;
    assign wr_data = in_split ? wd_hi    : wd_lo;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (hs && !fault && crossing) state_nx = ST_SPLIT;
            ST_SPLIT: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_fault <= 1'b0;
        end else begin
            state     <= state_nx;
            rsp_valid <= 1'b0;
            if (in_split || (hs && (fault || !crossing))) begin
                rsp_valid <= 1'b1;
                rsp_fault <= fault;
                rsp_rdata <= (fault || cur_we) ? 32'h0 : rdata;
            end
        end
    end

    // Low-beat read data is kept so a later store cannot disturb the merge.
    always_ff @(posedge clk) begin
        if (hs) begin
            cap_we    <= req_we;
            cap_type  <= req_type;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_rlo   <= mem[cur_word];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[wr_word][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    generate
        if (TRACE != 0) begin : g_trace
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wr_be[i])
                            $display("dm_param write addr=%0h data=%02h",
                                     {wr_word, 2'(i)}, wr_data[8*i +: 8]);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dm_param.sv
// Self-checking bench for dm_param: directed vector table, reset/back-to-back
// sequences and random accesses against a byte-array reference model.
module tb_dm_param;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        v1, v0;
    logic        req_we;
    logic [2:0]  req_type;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        ready1, vld1, flt1, ready0, vld0, flt0;
    logic [31:0] rd1, rd0;

    int n_checks = 0;
    int n_errors = 0;
    byte unsigned mm [512];

    always #5 clk = ~clk;

    dm_param #(.ADDR_W(9), .ALLOW_MISALIGN(1), .TRACE(0)) dut (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(ready1), .req_we(req_we),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld1), .rsp_rdata(rd1), .rsp_fault(flt1)
    );

    dm_param #(.ADDR_W(9), .ALLOW_MISALIGN(0), .TRACE(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(ready0), .req_we(req_we),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld0), .rsp_rdata(rd0), .rsp_fault(flt0)
    );

    typedef struct {
        bit          we;
        logic [2:0]  t;
        logic [8:0]  a;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          f;
        int          lat;
    } vec_t;

    localparam int NV = 22;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sz(input logic [2:0] t);
        case (t)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    // Reference: byte-by-byte access with wrap-around, extension by arithmetic.
    task automatic m_acc(input bit we, input logic [2:0] t, input int a, input logic [31:0] wd,
                         input bit allow, output logic [31:0] rd, output bit f, output int lat);
        int s;
        logic [31:0] v;
        s   = sz(t);
        rd  = 32'h0;
        f   = 1'b0;
        lat = 1;
        if (s == 0 || ((a % 4) + s > 4 && !allow)) begin
            f = 1'b1;
            return;
        end
        if ((a % 4) + s > 4) lat = 2;
        if (we) begin
            for (int i = 0; i < s; i++) mm[(a + i) % 512] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < s; i++) v[8*i +: 8] = mm[(a + i) % 512];
            if (t == 3'd1 && v[15]) v = v | 32'hFFFF0000;
            if (t == 3'd3 && v[7])  v = v | 32'hFFFFFF00;
            rd = v;
        end
    endtask

    task automatic txn(input string tag, input bit which, input bit we, input logic [2:0] t,
                       input logic [8:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output bit f, output int lat, output bit rdy);
        logic got;
        @(negedge clk);
        req_we = we; req_type = t; req_addr = a; req_wdata = wd;
        if (which) v0 = 1'b1; else v1 = 1'b1;
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b0;
        rdy = which ? ready0 : ready1;
        // Fields changing after acceptance must not affect the access.
        req_we = 1'($urandom); req_type = 3'($urandom); req_addr = 9'($urandom); req_wdata = $urandom;
        lat = 1;
        got = which ? vld0 : vld1;
        while (!got && lat < 6) begin
            @(posedge clk); #1;
            lat++;
            got = which ? vld0 : vld1;
        end
        rd = which ? rd0 : rd1;
        f  = which ? flt0 : flt1;
        @(posedge clk); #1;
        chk({tag, "_hold_valid"}, which ? vld0 : vld1, 1'b0);
        chk({tag, "_hold_rdata"}, which ? rd0 : rd1, rd);
    endtask

    task automatic check_txn(input string tag, input bit which, input bit we, input logic [2:0] t,
                             input logic [8:0] a, input logic [31:0] wd);
        logic [31:0] erd, ard;
        bit ef, af, ardy;
        int elat, alat;
        m_acc(we, t, int'(a), wd, !which, erd, ef, elat);
        txn(tag, which, we, t, a, wd, ard, af, alat, ardy);
        chk({tag, "_rdata"}, ard, erd);
        chk({tag, "_fault"}, af, ef);
        chk({tag, "_latency"}, alat, elat);
        chk({tag, "_ready"}, ardy, elat == 1);
    endtask

    initial begin
        vec_t        vt [NV];
        logic [31:0] erd, ard;
        bit          ef, af, ardy;
        int          elat, alat;

        vt = '{
            '{1'b1, DM_WORD,  9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 1},
            '{1'b0, DM_WORD,  9'h010, 32'h0,        32'hDEADBEEF, 1'b0, 1},
            '{1'b1, DM_BYTE,  9'h021, 32'h00000080, 32'h00000000, 1'b0, 1},
            '{1'b0, DM_BYTE,  9'h021, 32'h0,        32'hFFFFFF80, 1'b0, 1},
            '{1'b0, DM_BYTEU, 9'h021, 32'h0,        32'h00000080, 1'b0, 1},
            '{1'b0, DM_WORD,  9'h020, 32'h0,        32'h00008000, 1'b0, 1},
            '{1'b1, DM_WORD,  9'h00D, 32'h11223344, 32'h00000000, 1'b0, 2},
            '{1'b0, DM_WORD,  9'h00C, 32'h0,        32'h22334400, 1'b0, 1},
            '{1'b0, DM_BYTE,  9'h010, 32'h0,        32'h00000011, 1'b0, 1},
            '{1'b0, DM_HALF,  9'h00E, 32'h0,        32'h00002233, 1'b0, 1},
            '{1'b0, DM_WORD,  9'h00F, 32'h0,        32'hADBE1122, 1'b0, 2},
            '{1'b0, DM_HALF,  9'h011, 32'h0,        32'hFFFFADBE, 1'b0, 1},
            '{1'b0, DM_HALFU, 9'h013, 32'h0,        32'h000000DE, 1'b0, 2},
            '{1'b1, 3'b111,   9'h010, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1},
            '{1'b0, DM_WORD,  9'h010, 32'h0,        32'hDEADBE11, 1'b0, 1},
            '{1'b0, 3'b101,   9'h010, 32'h0,        32'h00000000, 1'b1, 1},
            '{1'b1, DM_WORD,  9'h1FF, 32'hCAFEF00D, 32'h00000000, 1'b0, 2},
            '{1'b0, DM_WORD,  9'h1FF, 32'h0,        32'hCAFEF00D, 1'b0, 2},
            '{1'b0, DM_WORD,  9'h000, 32'h0,        32'h00CAFEF0, 1'b0, 1},
            '{1'b1, DM_HALF,  9'h1FE, 32'hABCD8001, 32'h00000000, 1'b0, 1},
            '{1'b0, DM_HALF,  9'h1FE, 32'h0,        32'hFFFF8001, 1'b0, 1},
            '{1'b0, DM_WORD,  9'h1FF, 32'h0,        32'hCAFEF080, 1'b0, 2}
        };

        rst = 1'b1; v1 = 1'b0; v0 = 1'b0;
        req_we = 1'b0; req_type = 3'b0; req_addr = 9'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", vld1, 1'b0);
        chk("reset_rdata", rd1, 32'h0);
        chk("reset_fault", flt1, 1'b0);
        chk("reset_ready", ready1, 1'b1);
        chk("reset_ready0", ready0, 1'b1);
        rst = 1'b0;

        for (int w = 0; w < 128; w++)
            check_txn("init", 1'b0, 1'b1, DM_WORD, 9'(w * 4), 32'h0);

        for (int k = 0; k < NV; k++) begin
            m_acc(vt[k].we, vt[k].t, int'(vt[k].a), vt[k].wd, 1'b1, erd, ef, elat);
            txn($sformatf("vec%0d", k), 1'b0, vt[k].we, vt[k].t, vt[k].a, vt[k].wd, ard, af, alat, ardy);
            chk($sformatf("vec%0d_rdata", k), ard, vt[k].rd);
            chk($sformatf("vec%0d_fault", k), af, vt[k].f);
            chk($sformatf("vec%0d_latency", k), alat, vt[k].lat);
            chk($sformatf("vec%0d_ready", k), ardy, vt[k].lat == 1);
        end

        // Reset wins over a handshake in the same cycle.
        check_txn("fault6", 1'b0, 1'b0, 3'b110, 9'h030, 32'h0);
        @(negedge clk);
        rst = 1'b1; v1 = 1'b1;
        req_we = 1'b1; req_type = DM_BYTE; req_addr = 9'h030; req_wdata = 32'h5A;
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("rstdom_valid", vld1, 1'b0);
        chk("rstdom_fault", flt1, 1'b0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rstdom_late_valid", vld1, 1'b0);
        check_txn("rstdom_load", 1'b0, 1'b0, DM_BYTEU, 9'h030, 32'h0);

        // Load accepted the cycle right after a store to the same bytes.
        m_acc(1'b1, DM_HALF, 'h40, 32'h00001234, 1'b1, erd, ef, elat);
        m_acc(1'b0, DM_HALFU, 'h40, 32'h0, 1'b1, erd, ef, elat);
        @(negedge clk);
        req_we = 1'b1; req_type = DM_HALF; req_addr = 9'h040; req_wdata = 32'h00001234; v1 = 1'b1;
        @(posedge clk); #1;
        chk("b2b_st_valid", vld1, 1'b1);
        chk("b2b_st_rdata", rd1, 32'h0);
        chk("b2b_st_ready", ready1, 1'b1);
        req_we = 1'b0; req_type = DM_HALFU;
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("b2b_ld_valid", vld1, 1'b1);
        chk("b2b_ld_rdata", rd1, erd);

        // Reset during the second beat of a crossing store.
        check_txn("pre_rst_load", 1'b0, 1'b0, DM_WORD, 9'h010, 32'h0);
        @(negedge clk);
        req_we = 1'b1; req_type = DM_WORD; req_addr = 9'h00E; req_wdata = 32'h55667788; v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("split_ready", ready1, 1'b0);
        chk("split_valid", vld1, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("splitrst_valid", vld1, 1'b0);
        chk("splitrst_rdata", rd1, 32'h0);
        chk("splitrst_fault", flt1, 1'b0);
        chk("splitrst_ready", ready1, 1'b1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("splitrst_late_valid", vld1, 1'b0);
        mm[14] = 8'h88;
        mm[15] = 8'h77;
        check_txn("splitrst_lo", 1'b0, 1'b0, DM_WORD, 9'h00C, 32'h0);
        check_txn("splitrst_hi", 1'b0, 1'b0, DM_WORD, 9'h010, 32'h0);

        // Instance without misaligned support: crossing accesses fault.
        check_txn("nomis_ldw", 1'b1, 1'b0, DM_WORD, 9'h1FF, 32'h0);
        check_txn("nomis_sth", 1'b1, 1'b1, DM_HALF, 9'h0FF, 32'h0000BEEF);
        check_txn("nomis_bad", 1'b1, 1'b0, 3'b101, 9'h004, 32'h0);
        check_txn("after_nomis", 1'b0, 1'b0, DM_HALFU, 9'h0FF, 32'h0);

        for (int k = 0; k < 300; k++)
            check_txn($sformatf("rnd%0d", k), 1'b0, 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), 9'($urandom_range(0, 511)), $urandom);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit reached, expected run complete");
        $fatal(1, "watchdog expired");
    end

endmodule
